// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: controller state encoding,
// the hard-wired zero register index and a register-match helper.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    DWAIT   = 2'd2,
    HALTED  = 2'd3
  } pctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A writer only conflicts with a reader when it targets a real register.
  function automatic logic regConflict(input logic wen, input logic [4:0] wsel,
                                       input logic [4:0] rsel);
    return wen && (wsel != REG_ZERO) && (wsel == rsel);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection for the decode stage.
// PIPELINE_CTRL_FORWARDING_EN defined: only a load in EX feeding ID stalls.
// Undefined: any pending EX or MEM writer of an ID source register stalls.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic       idUsesRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       exWen,
  input  logic       exMemToReg,
  input  logic [4:0] exWsel,
  input  logic       memWen,
  input  logic [4:0] memWsel,
  output logic       hazard
);

  logic exRaw;
  logic memRaw;
  logic loadUse;

  // Source-operand matches against each downstream writer; rt only counts when read.
  always_comb begin
    exRaw   = regConflict(exWen, exWsel, idRs) ||
              (idUsesRt && regConflict(exWen, exWsel, idRt));
    memRaw  = regConflict(memWen, memWsel, idRs) ||
              (idUsesRt && regConflict(memWen, memWsel, idRt));
    loadUse = exMemToReg && exRaw;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    hazard  = loadUse;
`else
    hazard  = loadUse || exRaw || memRaw;
`endif
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline latch control: stalls, flushes, data-wait freeze and halt.
// PIPELINE_CTRL_FORWARDING_EN selects load-use-only stalling with a one-cycle
// LDSTALL state; without it every RAW stalls and is re-checked each cycle.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int STALLW = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_WEN,
  input  logic              ex_MemToReg,
  input  logic [4:0]        ex_wsel,
  input  logic              mem_WEN,
  input  logic [4:0]        mem_wsel,
  input  logic              mem_dREN,
  input  logic              mem_dWEN,
  input  logic              mem_halt,
  input  logic              ex_brtaken,
  input  logic              ex_jump,
  output logic              pc_W,
  output logic              ifid_W,
  output logic              ifid_RST,
  output logic              idex_W,
  output logic              idex_RST,
  output logic              exmem_W,
  output logic              exmem_RST,
  output logic              memwb_W,
  output logic              halt_o,
  output logic [STALLW-1:0] stall_cnt
);

  pctrl_state_t      state;
  pctrl_state_t      nextState;
  pctrl_state_t      stallState;
  logic [STALLW-1:0] stallCnt;
  logic              hazard;
  logic              stallReq;
  logic              dataWait;
  logic              ctrlXfer;

  hazard_detect uHazard (
    .idUsesRt  (id_uses_rt),
    .idRs      (id_rs),
    .idRt      (id_rt),
    .exWen     (ex_WEN),
    .exMemToReg(ex_MemToReg),
    .exWsel    (ex_wsel),
    .memWen    (mem_WEN),
    .memWsel   (mem_wsel),
    .hazard    (hazard)
  );

  assign dataWait = (mem_dREN || mem_dWEN) && !dhit;
  assign ctrlXfer = ex_brtaken || ex_jump;

`ifdef PIPELINE_CTRL_FORWARDING_EN
  // The bubble inserted by a load-use stall resolves it, so skip re-checking once.
  assign stallReq   = hazard && (state != LDSTALL);
  assign stallState = LDSTALL;
`else
  assign stallReq   = hazard;
  assign stallState = RUN;
`endif

  // Prioritised latch enables/clears and next-state selection.
  always_comb begin
    pc_W      = 1'b1;
    ifid_W    = 1'b1;
    ifid_RST  = 1'b0;
    idex_W    = 1'b1;
    idex_RST  = 1'b0;
    exmem_W   = 1'b1;
    exmem_RST = 1'b0;
    memwb_W   = 1'b1;
    nextState = RUN;
    if (RST) begin
      pc_W      = 1'b0;
      ifid_RST  = 1'b1;
      idex_RST  = 1'b1;
      exmem_RST = 1'b1;
    end else if (state == HALTED) begin
      pc_W      = 1'b0;
      ifid_W    = 1'b0;
      idex_W    = 1'b0;
      exmem_W   = 1'b0;
      memwb_W   = 1'b0;
      nextState = HALTED;
    end else if (dataWait) begin
      pc_W      = 1'b0;
      ifid_W    = 1'b0;
      idex_W    = 1'b0;
      exmem_W   = 1'b0;
      memwb_W   = 1'b0;
      nextState = DWAIT;
    end else if (ctrlXfer) begin
      ifid_RST  = 1'b1;
      idex_RST  = 1'b1;
    end else if (stallReq) begin
      pc_W      = 1'b0;
      ifid_W    = 1'b0;
      idex_RST  = 1'b1;
      nextState = stallState;
    end else if (!ihit) begin
      pc_W      = 1'b0;
      ifid_RST  = 1'b1;
    end
    // A halt instruction retiring into WB stops the machine from next cycle on.
    if (!RST && mem_halt && memwb_W) begin
      nextState = HALTED;
    end
  end

  // State, halt flag and saturating stall counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= RUN;
      stallCnt <= '0;
      halt_o   <= 1'b0;
    end else begin
      state  <= nextState;
      halt_o <= (nextState == HALTED);
      if (!pc_W && (state != HALTED) && (stallCnt != '1)) begin
        stallCnt <= stallCnt + 1'b1;
      end
    end
  end

  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (STALLW=4) with hand-computed expectations.
module tb_pipeline_ctrl;

  localparam int STALLW = 4;
  // Control vector order: {pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST, memwb_W}
  localparam logic [7:0] V_RESET  = 8'b0111_1111;
  localparam logic [7:0] V_FREEZE = 8'b0000_0000;
  localparam logic [7:0] V_NORM   = 8'b1101_0101;
  localparam logic [7:0] V_BRANCH = 8'b1111_1101;
  localparam logic [7:0] V_STALL  = 8'b0001_1101;
  localparam logic [7:0] V_MISS   = 8'b0111_0101;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, id_uses_rt, ex_WEN, ex_MemToReg, mem_WEN;
  logic mem_dREN, mem_dWEN, mem_halt, ex_brtaken, ex_jump;
  logic [4:0] id_rs, id_rt, ex_wsel, mem_wsel;
  logic pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST, memwb_W, halt_o;
  logic [STALLW-1:0] stall_cnt;
  logic [7:0] ctl;

  int checks = 0;
  int failures = 0;

  assign ctl = {pc_W, ifid_W, ifid_RST, idex_W, idex_RST, exmem_W, exmem_RST, memwb_W};

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.STALLW(STALLW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_WEN(ex_WEN), .ex_MemToReg(ex_MemToReg), .ex_wsel(ex_wsel),
    .mem_WEN(mem_WEN), .mem_wsel(mem_wsel), .mem_dREN(mem_dREN),
    .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .ex_brtaken(ex_brtaken), .ex_jump(ex_jump),
    .pc_W(pc_W), .ifid_W(ifid_W), .ifid_RST(ifid_RST), .idex_W(idex_W),
    .idex_RST(idex_RST), .exmem_W(exmem_W), .exmem_RST(exmem_RST),
    .memwb_W(memwb_W), .halt_o(halt_o), .stall_cnt(stall_cnt)
  );

  task automatic clearInputs();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b1; id_uses_rt = 1'b0;
    ex_WEN = 1'b0; ex_MemToReg = 1'b0; mem_WEN = 1'b0;
    mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
    ex_brtaken = 1'b0; ex_jump = 1'b0;
    id_rs = 5'd0; id_rt = 5'd0; ex_wsel = 5'd0; mem_wsel = 5'd0;
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyReset();
    clearInputs();
    RST = 1'b1;
    stepCycle();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    clearInputs();
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl !== V_RESET) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, V_RESET); end
    stepCycle();
    RST = 1'b0;
    checks++;
    if (halt_o !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", halt_o); end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    $display("reset: ctl=%b halt_o=%b stall_cnt=%0d", ctl, halt_o, stall_cnt);
  endtask

  task automatic test_normal();
    applyReset();
    ex_WEN = 1'b1; ex_MemToReg = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0;
    mem_WEN = 1'b1; mem_wsel = 5'd0;
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL reg0_no_hazard got=%b exp=%b", ctl, V_NORM); end
    $display("normal/reg0: ctl=%b", ctl);
    stepCycle();
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL normal_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    applyReset();
    ex_MemToReg = 1'b1; ex_WEN = 1'b1; ex_wsel = 5'd5; id_rs = 5'd5;
    @(negedge CLK);
    checks++;
    if (ctl !== V_STALL) begin failures++; $display("FAIL loaduse_c1 got=%b exp=%b", ctl, V_STALL); end
    $display("load-use cycle1: ctl=%b", ctl);
    stepCycle();
`ifndef PIPELINE_CTRL_FORWARDING_EN
    // Without forwarding the stall is re-checked; the bubble now sits in EX.
    clearInputs();
`endif
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL loaduse_c2 got=%b exp=%b", ctl, V_NORM); end
    $display("load-use cycle2: ctl=%b", ctl);
    stepCycle();
    checks++;
    if (stall_cnt !== 4'd1) begin failures++; $display("FAIL loaduse_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_data_wait();
    applyReset();
    mem_dREN = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (ctl !== V_FREEZE) begin failures++; $display("FAIL dwait_c%0d got=%b exp=%b", i, ctl, V_FREEZE); end
      $display("data wait cycle%0d: ctl=%b", i, ctl);
      stepCycle();
    end
    dhit = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL dwait_exit got=%b exp=%b", ctl, V_NORM); end
    stepCycle();
    checks++;
    if (stall_cnt !== 4'd3) begin failures++; $display("FAIL dwait_cnt got=%0d exp=3", stall_cnt); end
    $display("data wait exit: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_branch_wait();
    applyReset();
    ex_brtaken = 1'b1; mem_dWEN = 1'b1; dhit = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctl !== V_FREEZE) begin failures++; $display("FAIL brwait_freeze got=%b exp=%b", ctl, V_FREEZE); end
    stepCycle();
    dhit = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl !== V_BRANCH) begin failures++; $display("FAIL brwait_flush got=%b exp=%b", ctl, V_BRANCH); end
    $display("branch+wait resolve: ctl=%b", ctl);
    stepCycle();
    clearInputs();
    ex_jump = 1'b1; ihit = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctl !== V_BRANCH) begin failures++; $display("FAIL jump_over_miss got=%b exp=%b", ctl, V_BRANCH); end
    stepCycle();
    clearInputs();
    ihit = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctl !== V_MISS) begin failures++; $display("FAIL fetch_miss got=%b exp=%b", ctl, V_MISS); end
    $display("fetch miss: ctl=%b", ctl);
    stepCycle();
  endtask

  task automatic test_halt();
    applyReset();
    mem_halt = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL halt_entry_ctl got=%b exp=%b", ctl, V_NORM); end
    stepCycle();
    clearInputs();
    ihit = 1'b0;
    checks++;
    if (halt_o !== 1'b1) begin failures++; $display("FAIL halt_o got=%b exp=1", halt_o); end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++;
      if (ctl !== V_FREEZE) begin failures++; $display("FAIL halted_c%0d got=%b exp=%b", i, ctl, V_FREEZE); end
      stepCycle();
    end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL halted_cnt got=%0d exp=0", stall_cnt); end
    $display("halted: halt_o=%b stall_cnt=%0d", halt_o, stall_cnt);
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl !== V_RESET) begin failures++; $display("FAIL halt_reset_ctl got=%b exp=%b", ctl, V_RESET); end
    stepCycle();
    clearInputs();
    checks++;
    if (halt_o !== 1'b0) begin failures++; $display("FAIL halt_cleared got=%b exp=0", halt_o); end
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL halt_run_again got=%b exp=%b", ctl, V_NORM); end
    $display("halt reset: halt_o=%b ctl=%b", halt_o, ctl);
    stepCycle();
  endtask

  task automatic test_reset_override();
    applyReset();
    mem_dREN = 1'b1; dhit = 1'b0;
    stepCycle();
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if (ctl !== V_RESET) begin failures++; $display("FAIL dwait_reset_ctl got=%b exp=%b", ctl, V_RESET); end
    stepCycle();
    clearInputs();
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL dwait_reset_cnt got=%0d exp=0", stall_cnt); end
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL dwait_reset_run got=%b exp=%b", ctl, V_NORM); end
    $display("reset during data wait: ctl=%b stall_cnt=%0d", ctl, stall_cnt);
    stepCycle();
  endtask

  task automatic test_saturation();
    applyReset();
    ihit = 1'b0;
    for (int i = 0; i < 14; i++) stepCycle();
    checks++;
    if (stall_cnt !== 4'd14) begin failures++; $display("FAIL sat_count14 got=%0d exp=14", stall_cnt); end
    for (int i = 14; i < 20; i++) stepCycle();
    checks++;
    if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt); end
    $display("saturation: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_raw_stall();
    applyReset();
    // rt matches but is not read: never a hazard.
    ex_WEN = 1'b1; ex_wsel = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b0; id_rs = 5'd7;
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL raw_rt_unused got=%b exp=%b", ctl, V_NORM); end
    id_uses_rt = 1'b1;
`ifdef PIPELINE_CTRL_FORWARDING_EN
    #1;
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL raw_fwd_ex got=%b exp=%b", ctl, V_NORM); end
    stepCycle();
`else
    #1;
    checks++;
    if (ctl !== V_STALL) begin failures++; $display("FAIL raw_ex got=%b exp=%b", ctl, V_STALL); end
    $display("raw ex writer: ctl=%b", ctl);
    stepCycle();
    ex_WEN = 1'b0; mem_WEN = 1'b1; mem_wsel = 5'd3;
    @(negedge CLK);
    checks++;
    if (ctl !== V_STALL) begin failures++; $display("FAIL raw_mem got=%b exp=%b", ctl, V_STALL); end
    $display("raw mem writer: ctl=%b", ctl);
    stepCycle();
    mem_WEN = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctl !== V_NORM) begin failures++; $display("FAIL raw_clear got=%b exp=%b", ctl, V_NORM); end
    stepCycle();
    checks++;
    if (stall_cnt !== 4'd2) begin failures++; $display("FAIL raw_cnt got=%0d exp=2", stall_cnt); end
    $display("raw cleared: stall_cnt=%0d", stall_cnt);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clearInputs();
    test_reset();
    test_normal();
    test_load_use();
    test_data_wait();
    test_branch_wait();
    test_halt();
    test_reset_override();
    test_saturation();
    test_raw_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
